frame_loader: RTL
=================

// Module: frame_loader
// PURPOSE
// Upstream writer for the frame buffer's port A. It takes a byte stream of pixel data
// (3 bytes per LED, first byte marked by S_SOF) and packs each 3 bytes into one 24-bit word.
// It writes the words to consecutive frame-buffer addresses, which the WS2812B driver
// scans out through port B. Runs in the port-A clock domain.
// PARAMETERS
// NUM_LEDS  512  pixels per frame; legal range 1..2**ADDR_W
// ADDR_W    10   frame-buffer address width
// PORTS
// CLK          in   1       port-A clock (100 MHz domain)
// RESET        in   1       synchronous, active-high reset
// S_DATA       in   8       stream byte
// S_VALID      in   1       S_DATA valid
// S_SOF        in   1       qualifies S_DATA as byte 0 of pixel 0 of a new frame
// S_READY      out  1       loader can accept a byte this cycle
// RAM_EN       out  1       frame-buffer port-A enable (ena)
// RAM_WE       out  1       frame-buffer port-A write enable (wea)
// RAM_ADDR     out  ADDR_W  frame-buffer port-A address (addra)
// RAM_DIN      out  24      frame-buffer port-A write data (dina)
// FRAME_DONE   out  1       1-cycle pulse: last pixel of a frame written
// FRAME_ABORT  out  1       1-cycle pulse: SOF arrived while a frame was incomplete
// FRAME_COUNT  out  16      completed-frame counter
// BEHAVIOUR
// - Byte accepted = S_VALID && S_READY at the rising CLK edge.
// - S_READY = !RESET && (state != WRITE). It is combinational from state and RESET.
// - States and transitions:
//   - IDLE: accept byte with SOF -> COLLECT, pix=0, bcnt=1. Accept byte without SOF -> drop, stay.
//   - COLLECT: accept byte without SOF -> pack byte, bcnt++.
//     - On the 3rd byte (bcnt==2) -> WRITE.
//   - COLLECT: accept byte with SOF -> restart. Pulse FRAME_ABORT, pix=0, byte is byte 0, bcnt=1.
//   - WRITE (exactly 1 cycle): drive RAM_EN=RAM_WE=1, RAM_ADDR=pix, RAM_DIN=packed word.
//     - Next state: if pix==NUM_LEDS-1 -> IDLE, pulse FRAME_DONE, FRAME_COUNT++.
//     - Otherwise -> COLLECT, pix++, bcnt=0.
// - Packing: byte0->RAM_DIN[23:16], byte1->[15:8], byte2->[7:0]. Bytes pass through unmodified.
// - Latency: RAM write strobe appears 1 cycle after the 3rd byte of a pixel is accepted.
// - All outputs are registered except S_READY.
// - RAM_EN/RAM_WE are 0 outside WRITE. RAM_ADDR/RAM_DIN hold their last value.
// - FRAME_DONE and FRAME_ABORT assert in the cycle after WRITE or after the SOF accept.
// - FRAME_COUNT wraps 0xFFFF->0x0000 with no flag.
// - Throughput: max 3 bytes per 4 cycles.
// - Reset: state=IDLE, pix=0, bcnt=0. RAM_EN=RAM_WE=0, RAM_ADDR=0, RAM_DIN=0.
//   FRAME_DONE=FRAME_ABORT=0, FRAME_COUNT=0, S_READY=0 while RESET is high.
// - Reset mid-frame: the partial pixel is discarded; pixels already written stay in RAM.
// - pix never exceeds NUM_LEDS-1. The address never wraps within a frame.
// - A frame shorter than NUM_LEDS that is never followed by SOF stays in COLLECT indefinitely.
// TESTING (NUM_LEDS=4 for sim)
// - Reset then 12 bytes 0x01..0x0C, SOF on first, S_VALID held.
//   -> writes addr0=0x010203, 1=0x040506, 2=0x070809, 3=0x0A0B0C.
//   -> S_READY low 1 cycle after each 3rd byte; FRAME_DONE 1 cycle; FRAME_COUNT=1.
// - 5 bytes without SOF in IDLE -> no RAM_WE, FRAME_COUNT stays 0.
// - SOF frame, 7 bytes, then new SOF + 12 bytes.
//   -> FRAME_ABORT 1 cycle, next write to addr0 with new data, FRAME_DONE once.
// - S_VALID toggling randomly 50% over a full frame -> same 4 writes/values as steady stream.
// - RESET asserted after byte 2 of pixel 1, then a full frame.
//   -> no write of pixel 1 from the old data; the new frame writes addr0..3 correctly.
// - Preload FRAME_COUNT path: 65536 frames (or forced state) -> count wraps to 0x0000.

Source files
------------

// File: rtl/frame_loader.sv
// frame_loader: packs an RGB byte stream into 24-bit words and writes them to frame-buffer port A
// Ports: CLK/RESET (sync, active-high); S_DATA/S_VALID/S_SOF/S_READY byte stream in;
// RAM_EN/RAM_WE/RAM_ADDR/RAM_DIN frame-buffer port A; FRAME_DONE/FRAME_ABORT pulses; FRAME_COUNT.
module frame_loader #(
  parameter int NUM_LEDS = 512,
  parameter int ADDR_W   = 10
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic [7:0]        S_DATA,
  input  logic              S_VALID,
  input  logic              S_SOF,
  output logic              S_READY,
  output logic              RAM_EN,
  output logic              RAM_WE,
  output logic [ADDR_W-1:0] RAM_ADDR,
  output logic [23:0]       RAM_DIN,
  output logic              FRAME_DONE,
  output logic              FRAME_ABORT,
  output logic [15:0]       FRAME_COUNT
);
  typedef enum logic [1:0] {IDLE, COLLECT, WRITE} state_t;
  state_t state, state_n;
  logic [ADDR_W-1:0] pix, pix_n, addr_n;
  logic [1:0] bcnt, bcnt_n;
  logic [7:0] b0, b1, b0_n, b1_n;
  logic [23:0] din_n;
  logic [15:0] cnt_n;
  logic wr_n, done_n, abort_n, acc, last;
  assign S_READY = !RESET && state != WRITE;
  assign acc = S_VALID && S_READY;
  assign last = pix == ADDR_W'(NUM_LEDS - 1);
  always_comb begin
    state_n = state;
    pix_n   = pix;
    bcnt_n  = bcnt;
    b0_n    = b0;
    b1_n    = b1;
    addr_n  = RAM_ADDR;
    din_n   = RAM_DIN;
    cnt_n   = FRAME_COUNT;
    wr_n    = 1'b0;
    done_n  = 1'b0;
    abort_n = 1'b0;
    case (state)
      IDLE:
        if (acc && S_SOF) begin
          state_n = COLLECT;
          pix_n   = '0;
          bcnt_n  = 2'd1;
          b0_n    = S_DATA;
        end
      COLLECT:
        if (acc) begin
          if (S_SOF) begin
            abort_n = 1'b1;
            pix_n   = '0;
            bcnt_n  = 2'd1;
            b0_n    = S_DATA;
          end else if (bcnt == 2'd2) begin
            state_n = WRITE;
            wr_n    = 1'b1;
            addr_n  = pix;
            din_n   = {b0, b1, S_DATA};
          end else begin
            bcnt_n = bcnt + 2'd1;
            b0_n   = bcnt == 2'd0 ? S_DATA : b0;
            b1_n   = bcnt == 2'd1 ? S_DATA : b1;
          end
        end
      WRITE: begin
        state_n = last ? IDLE : COLLECT;
        pix_n   = last ? pix : pix + 1'b1;
        bcnt_n  = 2'd0;
        done_n  = last;
        cnt_n   = last ? FRAME_COUNT + 16'd1 : FRAME_COUNT;
      end
      default: state_n = IDLE;
    endcase
  end
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state       <= IDLE;
      pix         <= '0;
      bcnt        <= '0;
      b0          <= '0;
      b1          <= '0;
      RAM_EN      <= 1'b0;
      RAM_WE      <= 1'b0;
      RAM_ADDR    <= '0;
      RAM_DIN     <= '0;
      FRAME_DONE  <= 1'b0;
      FRAME_ABORT <= 1'b0;
      FRAME_COUNT <= '0;
    end else begin
      state       <= state_n;
      pix         <= pix_n;
      bcnt        <= bcnt_n;
      b0          <= b0_n;
      b1          <= b1_n;
      RAM_EN      <= wr_n;
      RAM_WE      <= wr_n;
      RAM_ADDR    <= addr_n;
      RAM_DIN     <= din_n;
      FRAME_DONE  <= done_n;
      FRAME_ABORT <= abort_n;
      FRAME_COUNT <= cnt_n;
    end
  end
endmodule
